// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared constants and the sequencer state encoding for the ALU operand
//   sequencer and its register file.
//   Optional build macro used by the importing files: ALU_SEQ_DBG_READ_EN.
package alu_seq_pkg;

    localparam int DATA_W = 8;              // register / data width
    localparam int NREGS  = 4;              // register count
    localparam int ADDR_W = $clog2(NREGS);  // register index width
    localparam int ALU_W  = DATA_W + 1;     // ALU operand / result width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile
//   NREGS x DATA_W register file: synchronous active-high reset, one write
//   port, two combinational read ports. A third combinational read port is
//   added when ALU_SEQ_DBG_READ_EN is defined.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  write port (takes effect at the rising edge)
//   raddr1_i/rdata1_o     read port 1 (combinational)
//   raddr2_i/rdata2_o     read port 2 (combinational)
//   dbg_addr_i/dbg_data_o debug read port (ALU_SEQ_DBG_READ_EN only)
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
`ifdef ALU_SEQ_DBG_READ_EN
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
`endif
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

`ifdef ALU_SEQ_DBG_READ_EN
    assign dbg_data_o = regs_q[dbg_addr_i];
`endif

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Sequences one operation at a time around an external combinational 9-bit
//   ALU: IDLE -> FETCH (register operands) -> EXEC (ALU settles) -> WB
//   (write result back, update flags, pulse done) -> IDLE.
//   Optional build macro ALU_SEQ_DBG_READ_EN adds a debug register read port.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (accepted only in IDLE)
//   cmd_rs1/cmd_rs2/cmd_rd         operand and destination register indices
//   cmd_use_carry                  1: cin = carry flag, 0: cin = 0
//   ld_en/ld_addr/ld_data          direct register load (IDLE only)
//   alu_a1/alu_a2/alu_cin          registered operands to the ALU
//   alu_o                          ALU result (bit 8 = carry out)
//   done                           one-cycle pulse during writeback
//   result/carry_flag/zero_flag    last writeback value and flags
//   dbg_addr/dbg_data              debug read (ALU_SEQ_DBG_READ_EN only)
module alu_operand_sequencer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              cmd_use_carry,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ALU_W-1:0]  alu_a1,
    output logic [ALU_W-1:0]  alu_a2,
    output logic              alu_cin,
    input  logic [ALU_W-1:0]  alu_o,
`ifdef ALU_SEQ_DBG_READ_EN
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_flag,
    output logic              zero_flag
);

    state_e            state_q, state_d;
    logic              accept;

    logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic              use_carry_q;

    logic [ALU_W-1:0]  a1_q, a2_q;
    logic              cin_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q, zero_q;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

    // Next state and handshake. A load in IDLE blocks acceptance so the
    // load and the command never race for the register file.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !ld_en;
                if (cmd_valid && !ld_en) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = EXEC;
            EXEC:  state_d = WB;
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            use_carry_q <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            cin_q       <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rs1_q       <= cmd_rs1;
                rs2_q       <= cmd_rs2;
                rd_q        <= cmd_rd;
                use_carry_q <= cmd_use_carry;
            end
            // Operands are captured once and held until the next FETCH.
            if (state_q == FETCH) begin
                a1_q  <= {1'b0, rf_rdata1};
                a2_q  <= {1'b0, rf_rdata2};
                cin_q <= use_carry_q ? carry_q : 1'b0;
            end
            if (state_q == WB) begin
                result_q <= alu_o[DATA_W-1:0];
                carry_q  <= alu_o[DATA_W];
                zero_q   <= (alu_o[DATA_W-1:0] == '0);
            end
        end
    end

    // Single write port: WB and IDLE are exclusive, so writeback and load
    // never collide. Loads outside IDLE are dropped here.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
        if (state_q == WB) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = alu_o[DATA_W-1:0];
        end else if (state_q == IDLE && ld_en) begin
            rf_we = 1'b1;
        end
    end

    alu_seq_regfile u_regfile (
        .clk_i      (clk),
        .rst_i      (rst),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .raddr1_i   (rs1_q),
        .rdata1_o   (rf_rdata1),
`ifdef ALU_SEQ_DBG_READ_EN
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
`endif
        .raddr2_i   (rs2_q),
        .rdata2_o   (rf_rdata2)
    );

    assign alu_a1     = a1_q;
    assign alu_a2     = a2_q;
    assign alu_cin    = cin_q;
    assign result     = result_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule
